// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, legality check,
// FSM encoding and request word sizing. Optional chaining bit under ALU_SEQ_CHAIN_EN.
package alu_seq_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [OPC_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OPC_W-1:0] OP_AND = 4'b0001;
    localparam logic [OPC_W-1:0] OP_OR  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_GT  = 4'b0011;
    localparam logic [OPC_W-1:0] OP_XOR = 4'b0100;
    localparam logic [OPC_W-1:0] OP_MUL = 4'b0101;
    localparam logic [OPC_W-1:0] OP_SHL = 4'b0110;
    localparam logic [OPC_W-1:0] OP_EQ  = 4'b1000;
    localparam logic [OPC_W-1:0] OP_SHR = 4'b1100;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b1111;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_EXEC = 2'd1;
    localparam logic [STATE_W-1:0] S_HOLD = 2'd2;

`ifdef ALU_SEQ_CHAIN_EN
    localparam int unsigned CHAIN_W = 1;
`else
    localparam int unsigned CHAIN_W = 0;
`endif

    // Request word: {[chain,] sel, b, a}
    function automatic int unsigned req_width(input int unsigned opw);
        return 3 * opw + CHAIN_W;
    endfunction

    localparam int unsigned REQ_W = req_width(OPC_W);

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_AND, OP_OR, OP_GT, OP_XOR,
            OP_MUL, OP_SHL, OP_EQ, OP_SHR, OP_SUB: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Request FIFO for the ALU sequencer: power-of-2 depth, registered count,
// head word presented combinationally.
module alu_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        rd_data_c,
    output logic                    full_c,
    output logic                    empty_c,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign do_push_c = push && !full_c;
    assign do_pop_c  = pop && !empty_c;
    assign rd_data_c = mem[rd_ptr];

    // Storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit ALU: queues {A,B,Sel} requests, drives the ALU one
// request at a time and returns results via valid/ready. Chaining under ALU_SEQ_CHAIN_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OPW   = 4,
    parameter int unsigned RESW  = 8
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic [OPW-1:0]          IN_A,
    input  logic [OPW-1:0]          IN_B,
    input  logic [OPW-1:0]          IN_SEL,
    input  logic                    IN_VALID,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic                    IN_CHAIN,
`endif
    output logic                    IN_READY,
    output logic [$clog2(DEPTH):0]  OCC,
    output logic [OPW-1:0]          ALU_A,
    output logic [OPW-1:0]          ALU_B,
    output logic [OPW-1:0]          ALU_SEL,
    input  logic [RESW-1:0]         ALU_C,
    output logic [RESW-1:0]         OUT_C,
    output logic [OPW-1:0]          OUT_SEL,
    output logic                    OUT_ERR,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY
);

    localparam int unsigned RW = req_width(OPW);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_d;
    logic               pop_c;
    logic               capture_c;
    logic               release_c;

    logic [RW-1:0]      wr_req_c;
    logic [RW-1:0]      head_c;
    logic               full_c;
    logic               empty_c;
    logic [OPW-1:0]     head_a_c;
    logic [OPW-1:0]     head_b_c;
    logic [OPW-1:0]     head_sel_c;
    logic [OPW-1:0]     issue_a_c;
    logic               sel_legal_c;

`ifdef ALU_SEQ_CHAIN_EN
    assign wr_req_c  = {IN_CHAIN, IN_SEL, IN_B, IN_A};
    // Chained request takes A from the most recently captured result
    assign issue_a_c = head_c[3*OPW] ? OUT_C[OPW-1:0] : head_a_c;
`else
    assign wr_req_c  = {IN_SEL, IN_B, IN_A};
    assign issue_a_c = head_a_c;
`endif

    assign head_a_c   = head_c[OPW-1:0];
    assign head_b_c   = head_c[2*OPW-1:OPW];
    assign head_sel_c = head_c[3*OPW-1:2*OPW];

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_n),
        .push      (IN_VALID),
        .wr_data   (wr_req_c),
        .pop       (pop_c),
        .rd_data_c (head_c),
        .full_c    (full_c),
        .empty_c   (empty_c),
        .count     (OCC)
    );

    assign IN_READY = !full_c;

    // Opcodes wider than the 4-bit ALU encoding are legal only with zero upper bits
    assign sel_legal_c = is_legal_op(OPC_W'(ALU_SEL)) && ((ALU_SEL >> OPC_W) == '0);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        pop_c     = 1'b0;
        capture_c = 1'b0;
        release_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                capture_c = 1'b1;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (OUT_READY) begin
                    release_c = 1'b1;
                    if (!empty_c) begin
                        pop_c   = 1'b1;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU operand registers load only on pop and otherwise hold
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ALU_A   <= '0;
            ALU_B   <= '0;
            ALU_SEL <= '0;
        end else if (pop_c) begin
            ALU_A   <= issue_a_c;
            ALU_B   <= head_b_c;
            ALU_SEL <= head_sel_c;
        end
    end

    // Result register: illegal opcodes return zero with the error flag set
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            OUT_C     <= '0;
            OUT_SEL   <= '0;
            OUT_ERR   <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (capture_c) begin
            OUT_C     <= sel_legal_c ? ALU_C : '0;
            OUT_SEL   <= ALU_SEL;
            OUT_ERR   <= !sel_legal_c;
            OUT_VALID <= 1'b1;
        end else if (release_c) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the ALU_* ports.
module tb_alu_op_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned OPW   = 4;
    localparam int unsigned RESW  = 8;
    localparam int unsigned NVEC  = 12;

    logic                   CLK;
    logic                   RST_n;
    logic [OPW-1:0]         IN_A;
    logic [OPW-1:0]         IN_B;
    logic [OPW-1:0]         IN_SEL;
    logic                   IN_VALID;
`ifdef ALU_SEQ_CHAIN_EN
    logic                   IN_CHAIN;
`endif
    logic                   IN_READY;
    logic [$clog2(DEPTH):0] OCC;
    logic [OPW-1:0]         ALU_A;
    logic [OPW-1:0]         ALU_B;
    logic [OPW-1:0]         ALU_SEL;
    logic [RESW-1:0]        ALU_C;
    logic [RESW-1:0]        OUT_C;
    logic [OPW-1:0]         OUT_SEL;
    logic                   OUT_ERR;
    logic                   OUT_VALID;
    logic                   OUT_READY;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic [7:0] c;
        logic       err;
    } vec_t;

    vec_t vecs [NVEC];

    alu_op_sequencer #(
        .DEPTH (DEPTH),
        .OPW   (OPW),
        .RESW  (RESW)
    ) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_SEL    (IN_SEL),
        .IN_VALID  (IN_VALID),
`ifdef ALU_SEQ_CHAIN_EN
        .IN_CHAIN  (IN_CHAIN),
`endif
        .IN_READY  (IN_READY),
        .OCC       (OCC),
        .ALU_A     (ALU_A),
        .ALU_B     (ALU_B),
        .ALU_SEL   (ALU_SEL),
        .ALU_C     (ALU_C),
        .OUT_C     (OUT_C),
        .OUT_SEL   (OUT_SEL),
        .OUT_ERR   (OUT_ERR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU; illegal opcodes produce junk the sequencer must mask
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] sel);
        logic [7:0] r;
        case (sel)
            4'b0000: r = 8'(a) + 8'(b);
            4'b0001: r = 8'(a & b);
            4'b0010: r = 8'(a | b);
            4'b0011: r = {7'd0, a > b};
            4'b0100: r = 8'(a ^ b);
            4'b0101: r = 8'(a) * 8'(b);
            4'b0110: r = 8'(a) << b[2:0];
            4'b1000: r = {7'd0, a == b};
            4'b1100: r = 8'(a) >> b[2:0];
            4'b1111: r = 8'(a) - 8'(b);
            default: r = 8'hA5;
        endcase
        return r;
    endfunction

    assign ALU_C = alu_model(ALU_A, ALU_B, ALU_SEL);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (OUT_VALID) begin
                ok = 1'b1;
                return;
            end
            @(negedge CLK);
        end
    endtask

    // Single request into an idle block with OUT_READY high; checks latency and result
    task automatic run_one(input vec_t v, input string tag);
        @(negedge CLK);
        IN_A     = v.a;
        IN_B     = v.b;
        IN_SEL   = v.sel;
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        check({tag, "_occ_k"}, 32'(OCC), 32'd1);
        check({tag, "_valid_k"}, 32'(OUT_VALID), 32'd0);
        @(negedge CLK);
        check({tag, "_valid_k1"}, 32'(OUT_VALID), 32'd0);
        @(negedge CLK);
        check({tag, "_valid_k2"}, 32'(OUT_VALID), 32'd1);
        check({tag, "_c"}, 32'(OUT_C), 32'(v.c));
        check({tag, "_sel"}, 32'(OUT_SEL), 32'(v.sel));
        check({tag, "_err"}, 32'(OUT_ERR), 32'(v.err));
        @(negedge CLK);
        check({tag, "_consumed"}, 32'(OUT_VALID), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic seen;

        vecs[0]  = '{4'b0010, 4'b1000, 4'b0000, 8'h0A, 1'b0};
        vecs[1]  = '{4'b1011, 4'b0111, 4'b0101, 8'h4D, 1'b0};
        vecs[2]  = '{4'b1110, 4'b0001, 4'b0001, 8'h00, 1'b0};
        vecs[3]  = '{4'b0101, 4'b1010, 4'b0010, 8'h0F, 1'b0};
        vecs[4]  = '{4'b1001, 4'b0011, 4'b0011, 8'h01, 1'b0};
        vecs[5]  = '{4'b1111, 4'b0101, 4'b0100, 8'h0A, 1'b0};
        vecs[6]  = '{4'b0011, 4'b0010, 4'b0110, 8'h0C, 1'b0};
        vecs[7]  = '{4'b0111, 4'b0111, 4'b1000, 8'h01, 1'b0};
        vecs[8]  = '{4'b1000, 4'b0011, 4'b1100, 8'h01, 1'b0};
        vecs[9]  = '{4'b0011, 4'b0101, 4'b1111, 8'hFE, 1'b0};
        vecs[10] = '{4'b0011, 4'b0001, 4'b0111, 8'h00, 1'b1};
        vecs[11] = '{4'b0110, 4'b0110, 4'b1001, 8'h00, 1'b1};

        RST_n     = 1'b1;
        IN_A      = '0;
        IN_B      = '0;
        IN_SEL    = '0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
        IN_CHAIN  = 1'b0;
`endif
        #2 RST_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_occ", 32'(OCC), 32'd0);
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out_c", 32'(OUT_C), 32'd0);
        check("rst_alu_abs", {20'd0, ALU_A, ALU_B, ALU_SEL}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end

        // MUL then AND back to back: results two cycles apart
        @(negedge CLK);
        IN_A = 4'b1011; IN_B = 4'b0111; IN_SEL = 4'b0101; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_A = 4'b1110; IN_B = 4'b0001; IN_SEL = 4'b0001;
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("b2b_valid1", 32'(OUT_VALID), 32'd1);
        check("b2b_c1", 32'(OUT_C), 32'h4D);
        @(negedge CLK);
        check("b2b_gap", 32'(OUT_VALID), 32'd0);
        @(negedge CLK);
        check("b2b_valid2", 32'(OUT_VALID), 32'd1);
        check("b2b_c2", 32'(OUT_C), 32'h00);
        check("b2b_sel2", 32'(OUT_SEL), 32'h1);
        @(negedge CLK);

        // Backpressure: one request held plus DEPTH queued, further pushes refused
        OUT_READY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            check($sformatf("bp_ready%0d", i), 32'(IN_READY), (i < 5) ? 32'd1 : 32'd0);
            IN_A = 4'(i + 1); IN_B = 4'd1; IN_SEL = 4'b0000; IN_VALID = 1'b1;
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        check("bp_occ_full", 32'(OCC), 32'd4);
        check("bp_in_ready", 32'(IN_READY), 32'd0);
        for (int h = 0; h < 3; h++) begin
            @(negedge CLK);
            check("bp_hold_valid", 32'(OUT_VALID), 32'd1);
            check("bp_hold_c", 32'(OUT_C), 32'd2);
        end
        OUT_READY = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_valid(ok);
            check($sformatf("bp_timeout%0d", j), 32'(ok), 32'd1);
            check($sformatf("bp_order%0d", j), 32'(OUT_C), 32'(j + 2));
            @(negedge CLK);
        end
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (OUT_VALID) seen = 1'b1;
            @(negedge CLK);
        end
        check("bp_no_extra", 32'(seen), 32'd0);
        check("bp_occ_empty", 32'(OCC), 32'd0);

        // Reset while a request executes and another is queued
        OUT_READY = 1'b0;
        @(negedge CLK);
        IN_A = 4'd1; IN_B = 4'd1; IN_SEL = 4'b0000; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_A = 4'd2; IN_B = 4'd2;
        @(negedge CLK);
        IN_A = 4'd3; IN_B = 4'd3;
        @(negedge CLK);
        IN_VALID = 1'b0;
        check("mr_pre_valid", 32'(OUT_VALID), 32'd1);
        check("mr_pre_occ", 32'(OCC), 32'd2);
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("mr_exec_alu_a", 32'(ALU_A), 32'd2);
        check("mr_exec_occ", 32'(OCC), 32'd1);
        RST_n = 1'b0;
        #1;
        check("mr_valid", 32'(OUT_VALID), 32'd0);
        check("mr_occ", 32'(OCC), 32'd0);
        check("mr_in_ready", 32'(IN_READY), 32'd1);
        check("mr_out_c", 32'(OUT_C), 32'd0);
        check("mr_alu_a", 32'(ALU_A), 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge CLK);
            if (OUT_VALID) seen = 1'b1;
        end
        check("mr_no_stale", 32'(seen), 32'd0);
        run_one(vecs[0], "post_rst");

`ifdef ALU_SEQ_CHAIN_EN
        // Accumulate chain: second ADD takes A from the first result
        @(negedge CLK);
        IN_A = 4'b0010; IN_B = 4'b0011; IN_SEL = 4'b0000; IN_CHAIN = 1'b0; IN_VALID = 1'b1;
        @(negedge CLK);
        IN_A = 4'b1111; IN_B = 4'b0100; IN_CHAIN = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0; IN_CHAIN = 1'b0;
        @(negedge CLK);
        check("chain_c1", 32'(OUT_C), 32'h05);
        @(negedge CLK);
        @(negedge CLK);
        check("chain_valid2", 32'(OUT_VALID), 32'd1);
        check("chain_c2", 32'(OUT_C), 32'h09);
        @(negedge CLK);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
